// File: rtl/pheap_level_pkg.sv
// Shared types for the pipelined heap: key/value payload (pq_pkg) and
// per-level node, opcode and handshake types (pheapTypes).
package pq_pkg;
    localparam int KEY_W = 8;
    localparam int VAL_W = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] value;
    } kv_t;

    localparam kv_t KV_EMPTY = '{key: '0, value: '0};
endpackage

package pheapTypes;
    import pq_pkg::*;

    localparam int LEVELS = 3;
    localparam int CAP_W  = LEVELS;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_LEQ = 2'd1,
        OP_DEQ = 2'd2,
        OP_RSV = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        WAIT       = 2'd0,
        NEXT_LEVEL = 2'd1,
        DONE       = 2'd2
    } done_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } lvl_state_t;

    typedef struct packed {
        kv_t              kv;
        logic [CAP_W-1:0] capacity;
        logic             active;
    } entry_t;

    localparam entry_t ENTRY_EMPTY = '{kv: KV_EMPTY, capacity: '0, active: 1'b0};

    // Protocol-check flag positions
    localparam int CHK_OP    = 0;
    localparam int CHK_START = 1;
    localparam int CHK_FULL  = 2;
    localparam int CHK_IDLE  = 3;
    localparam int CHK_OVF   = 4;
    localparam int CHK_N     = 5;

    // Free slots in the subtree rooted at a node of the given level.
    function automatic logic [CAP_W-1:0] cap_reset(input int level);
        return CAP_W'((1 << (LEVELS - level + 1)) - 1);
    endfunction
endpackage

// File: rtl/pheap_level_mem.sv
// Node storage for one heap level: one synchronous write port, a
// combinational child-pair read for the parent and a single read for this level.
module pheap_level_mem
    import pq_pkg::*;
    import pheapTypes::*;
#(
    parameter int LEVEL = 2,
    localparam int N  = 1 << (LEVEL - 1),
    localparam int TW = (LEVEL > 2) ? LEVEL - 2 : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [LEVEL-2:0] waddr_i,
    input  entry_t           wdata_i,
    input  logic [TW-1:0]    raddr_top_i,
    input  logic [LEVEL-2:0] raddr_i,
    output entry_t           rd_l_o,
    output entry_t           rd_r_o,
    output entry_t           rd_o
);
    entry_t           mem_q [N];
    logic [LEVEL-2:0] idx_l;
    logic [LEVEL-2:0] idx_r;

    generate
        if (LEVEL > 2) begin : g_pair
            assign idx_l = {raddr_top_i, 1'b0};
            assign idx_r = {raddr_top_i, 1'b1};
        end else begin : g_single_pair
            // Level 2 holds exactly one sibling pair, so the parent index is moot.
            logic unused_top;
            assign unused_top = ^raddr_top_i;
            assign idx_l = 1'b0;
            assign idx_r = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '{kv: KV_EMPTY, capacity: cap_reset(LEVEL), active: 1'b0};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_l_o = mem_q[idx_l];
    assign rd_r_o = mem_q[idx_r];
    assign rd_o   = mem_q[raddr_i];
endmodule

// File: rtl/pheap_level.sv
// Lower-level pipelined-heap stage: push-down enqueue / refill dequeue on one node.
// Optional protocol checking is enabled with PHEAP_LEVEL_CHECK_EN.
//   state   | meaning
//   ST_IDLE | waiting for start from the level above
//   ST_EXEC | one-cycle execute: node write and optional forward downward
module pheap_level
    import pq_pkg::*;
    import pheapTypes::*;
#(
    parameter int LEVEL = 2,
    localparam int TW = (LEVEL > 2) ? LEVEL - 2 : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  opcode_t          op,
    input  kv_t              in,
    input  logic [LEVEL-2:0] pos,
    input  logic [TW-1:0]    raddrTop,
    output entry_t           rTopL,
    output entry_t           rTopR,
    input  entry_t           rBotL,
    input  entry_t           rBotR,
    output logic [LEVEL-2:0] raddrBot,
    output logic             startBot,
    output opcode_t          opBot,
    output kv_t              out,
    output logic [LEVEL-1:0] posBot,
    output done_t            done,
    output logic             err
);
    localparam bit LAST = (LEVEL == LEVELS);

    lvl_state_t       state_q, state_d;
    opcode_t          op_q, op_d;
    kv_t              in_q, in_d;
    logic [LEVEL-2:0] pos_q, pos_d;

    entry_t           node;
    entry_t           wdata;
    logic             we;
    kv_t              keep;
    kv_t              push;
    logic             end_pos;
    logic             side;
    logic [CAP_W-1:0] cap_dec;
    logic [CAP_W-1:0] cap_inc;
    logic [CHK_N-1:0] chk_vec;

    pheap_level_mem #(.LEVEL(LEVEL)) u_mem (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we),
        .waddr_i     (pos_q),
        .wdata_i     (wdata),
        .raddr_top_i (raddrTop),
        .raddr_i     (pos_q),
        .rd_l_o      (rTopL),
        .rd_r_o      (rTopR),
        .rd_o        (node)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            in_q    <= KV_EMPTY;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            in_q    <= in_d;
            pos_q   <= pos_d;
        end
    end

    assign raddrBot = pos_q;

    // Descend toward the subtree with room; prefer the smaller-key side when both have room.
    always_comb begin
        end_pos = 1'b1;
        if (rBotL.capacity != '0 && rBotR.capacity != '0) begin
            end_pos = (rBotL.kv.key <= rBotR.kv.key) ? 1'b0 : 1'b1;
        end else if (rBotL.capacity != '0) begin
            end_pos = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        in_d     = in_q;
        pos_d    = pos_q;
        we       = 1'b0;
        wdata    = node;
        done     = DONE;
        startBot = 1'b0;
        opBot    = op_q;
        out      = KV_EMPTY;
        posBot   = '0;
        chk_vec  = '0;
        keep     = node.kv;
        push     = in_q;
        side     = 1'b0;
        cap_dec  = (node.capacity == '0) ? '0 : node.capacity - 1'b1;
        cap_inc  = node.capacity + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    in_d    = in;
                    pos_d   = pos;
                    done    = WAIT;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d          = ST_IDLE;
                chk_vec[CHK_START] = start;
                case (op_q)
                    OP_LEQ: begin
                        we = 1'b1;
                        if (!node.active) begin
                            wdata = '{kv: in_q, capacity: cap_dec, active: 1'b1};
                        end else begin
                            if (in_q.key > node.kv.key) begin
                                keep = in_q;
                                push = node.kv;
                            end
                            wdata = '{kv: keep, capacity: cap_dec, active: 1'b1};
                            if (LAST) begin
                                chk_vec[CHK_FULL] = 1'b1;
                            end else begin
                                done     = NEXT_LEVEL;
                                startBot = 1'b1;
                                out      = push;
                                posBot   = {pos_q, end_pos};
                            end
                        end
                    end
                    OP_DEQ: begin
                        we                = 1'b1;
                        chk_vec[CHK_IDLE] = !node.active;
                        chk_vec[CHK_OVF]  = (node.capacity >= cap_reset(LEVEL));
                        if (!rBotL.active && !rBotR.active) begin
                            wdata = '{kv: KV_EMPTY, capacity: cap_inc, active: 1'b0};
                        end else begin
                            side     = !(rBotL.active &&
                                         (!rBotR.active || rBotL.kv.key >= rBotR.kv.key));
                            wdata    = '{kv: side ? rBotR.kv : rBotL.kv,
                                         capacity: cap_inc, active: 1'b1};
                            done     = NEXT_LEVEL;
                            startBot = 1'b1;
                            posBot   = {pos_q, side};
                        end
                    end
                    default: chk_vec[CHK_OP] = 1'b1;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef PHEAP_LEVEL_CHECK_EN
    logic err_q, err_d;

    assign err_d = err_q | (|chk_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!chk_vec[CHK_OP])    else $warning("pheap_level L%0d: illegal opcode", LEVEL);
            assert (!chk_vec[CHK_START]) else $warning("pheap_level L%0d: start while busy", LEVEL);
            assert (!chk_vec[CHK_FULL])  else $warning("pheap_level L%0d: enqueue into full leaf", LEVEL);
            assert (!chk_vec[CHK_IDLE])  else $warning("pheap_level L%0d: dequeue of empty node", LEVEL);
            assert (!chk_vec[CHK_OVF])   else $warning("pheap_level L%0d: capacity overflow", LEVEL);
        end
    end

    assign err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^chk_vec;
    assign err        = 1'b0;
`endif
endmodule

// File: tb/tb_pheap_level.sv
// Self-checking bench for pheap_level: a level-2 and a last-level (3) instance
// compared every cycle against a node-array model, plus literal spot checks.
module tb_pheap_level;
    import pq_pkg::*;
    import pheapTypes::*;

`ifdef PHEAP_LEVEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_v [2];
    opcode_t    op_v    [2];
    kv_t        in_v    [2];
    logic [1:0] pos_v   [2];
    logic [0:0] rtop2, rtop3;
    entry_t     bl2, br2;
    bit         tog_en;

    entry_t     rTopL2, rTopR2, rTopL3, rTopR3;
    logic [0:0] raddrBot2;
    logic [1:0] raddrBot3;
    logic       startBot2, startBot3, err2, err3;
    opcode_t    opBot2, opBot3;
    kv_t        out2, out3;
    logic [1:0] posBot2;
    logic [2:0] posBot3;
    done_t      done2, done3;

    pheap_level #(.LEVEL(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]), .in(in_v[0]),
        .pos(pos_v[0][0:0]), .raddrTop(rtop2), .rTopL(rTopL2), .rTopR(rTopR2),
        .rBotL(bl2), .rBotR(br2), .raddrBot(raddrBot2), .startBot(startBot2),
        .opBot(opBot2), .out(out2), .posBot(posBot2), .done(done2), .err(err2)
    );

    pheap_level #(.LEVEL(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]), .in(in_v[1]),
        .pos(pos_v[1]), .raddrTop(rtop3), .rTopL(rTopL3), .rTopR(rTopR3),
        .rBotL(ENTRY_EMPTY), .rBotR(ENTRY_EMPTY), .raddrBot(raddrBot3), .startBot(startBot3),
        .opBot(opBot3), .out(out3), .posBot(posBot3), .done(done3), .err(err3)
    );

    int errors = 0;
    int checks = 0;

    // Model: node array per instance, pending write/err applied at the next edge.
    entry_t  m     [2][4];
    bit      m_err [2];
    bit      p_we  [2];
    int      p_addr[2];
    entry_t  p_data[2];
    bit      p_err [2];
    done_t   e_done[2];
    bit      e_sb  [2];
    opcode_t e_op  [2];
    kv_t     e_out [2];
    int      e_pb  [2];
    bit      e_exec[2];
    int      e_pos [2];
    bit      chk_on = 1'b0;
    bit      skip   = 1'b0;

    done_t c_wait, c_done;
    bit    c_sb;
    kv_t   c_out;
    int    c_pb;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic kv_t kvf(input int k, input int v);
        kv_t r;
        r.key   = k[KEY_W-1:0];
        r.value = v[VAL_W-1:0];
        return r;
    endfunction

    function automatic entry_t ent(input kv_t kv, input int cap, input bit act);
        entry_t e;
        e.kv       = kv;
        e.capacity = cap[CAP_W-1:0];
        e.active   = act;
        return e;
    endfunction

    task automatic set_idle(input int d);
        e_done[d] = DONE;
        e_sb[d]   = 1'b0;
        e_out[d]  = KV_EMPTY;
        e_exec[d] = 1'b0;
        e_pb[d]   = 0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) m[d][i] = ent(KV_EMPTY, (2 ** (LEVELS - (d + 2) + 1)) - 1, 1'b0);
            m_err[d] = 1'b0;
            p_err[d] = 1'b0;
            p_we[d]  = 1'b0;
            set_idle(d);
        end
    endtask

    task automatic commit();
        for (int d = 0; d < 2; d++) begin
            if (p_we[d]) m[d][p_addr[d]] = p_data[d];
            if (p_err[d]) m_err[d] = 1'b1;
            p_we[d]  = 1'b0;
            p_err[d] = 1'b0;
        end
    endtask

    task automatic model_exec(input int d, input opcode_t op, input kv_t kv, input int p,
                              input entry_t bl, input entry_t br);
        entry_t n, w;
        kv_t    lo;
        int     lvl, cmax, sd;
        lvl  = d + 2;
        cmax = (2 ** (LEVELS - lvl + 1)) - 1;
        n    = m[d][p];
        w    = n;
        set_idle(d);
        e_exec[d] = 1'b1;
        e_pos[d]  = p;
        e_op[d]   = op;
        if (op == OP_LEQ) begin
            w.capacity = (n.capacity == 0) ? '0 : n.capacity - 1;
            w.active   = 1'b1;
            if (!n.active) begin
                w.kv = kv;
            end else begin
                w.kv = (kv.key > n.kv.key) ? kv : n.kv;
                lo   = (kv.key > n.kv.key) ? n.kv : kv;
                if (lvl == LEVELS) begin
                    if (CHK) p_err[d] = 1'b1;
                end else begin
                    if (bl.capacity != 0 && br.capacity != 0) sd = (bl.kv.key <= br.kv.key) ? 0 : 1;
                    else sd = (bl.capacity != 0) ? 0 : 1;
                    e_done[d] = NEXT_LEVEL;
                    e_sb[d]   = 1'b1;
                    e_out[d]  = lo;
                    e_pb[d]   = p * 2 + sd;
                end
            end
            p_we[d] = 1'b1; p_addr[d] = p; p_data[d] = w;
        end else if (op == OP_DEQ) begin
            if (CHK && (!n.active || n.capacity >= cmax)) p_err[d] = 1'b1;
            w.capacity = n.capacity + 1;
            if (!bl.active && !br.active) begin
                w.kv     = KV_EMPTY;
                w.active = 1'b0;
            end else begin
                if (!bl.active)      sd = 1;
                else if (!br.active) sd = 0;
                else                 sd = (br.kv.key > bl.kv.key) ? 1 : 0;
                w.kv      = (sd == 1) ? br.kv : bl.kv;
                w.active  = 1'b1;
                e_done[d] = NEXT_LEVEL;
                e_sb[d]   = 1'b1;
                e_pb[d]   = p * 2 + sd;
            end
            p_we[d] = 1'b1; p_addr[d] = p; p_data[d] = w;
        end else begin
            if (CHK) p_err[d] = 1'b1;
        end
    endtask

    task automatic cmp(input int d, input done_t dn, input logic sb, input opcode_t ob,
                       input kv_t o, input int pb, input logic er, input entry_t tl,
                       input entry_t tr, input int rb, input int rt);
        int il;
        il = (d == 0) ? 0 : rt * 2;
        chk($sformatf("L%0d done", d + 2), dn, e_done[d]);
        chk($sformatf("L%0d startBot", d + 2), sb, e_sb[d]);
        chk($sformatf("L%0d out", d + 2), o, e_out[d]);
        if (e_sb[d]) begin
            chk($sformatf("L%0d opBot", d + 2), ob, e_op[d]);
            chk($sformatf("L%0d posBot", d + 2), pb, e_pb[d]);
        end
        if (e_exec[d]) chk($sformatf("L%0d raddrBot", d + 2), rb, e_pos[d]);
        chk($sformatf("L%0d err", d + 2), er, m_err[d]);
        chk($sformatf("L%0d rTopL", d + 2), tl, m[d][il]);
        chk($sformatf("L%0d rTopR", d + 2), tr, m[d][il + 1]);
    endtask

    always @(negedge clk) begin
        if (chk_on && !skip) begin
            cmp(0, done2, startBot2, opBot2, out2, int'(posBot2), err2, rTopL2, rTopR2,
                int'(raddrBot2), 0);
            cmp(1, done3, startBot3, opBot3, out3, int'(posBot3), err3, rTopL3, rTopR3,
                int'(raddrBot3), int'(rtop3));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tog_en) rtop3 = ~rtop3;
        end
    end

    task automatic do_op(input int d, input opcode_t op, input kv_t kv, input int p,
                         input entry_t bl, input entry_t br, input bit rst_mid);
        @(posedge clk); #1;
        commit();
        start_v[d] = 1'b1; op_v[d] = op; in_v[d] = kv; pos_v[d] = p[1:0];
        if (d == 0) begin bl2 = bl; br2 = br; end
        e_done[d] = WAIT;
        @(negedge clk);
        c_wait = (d == 0) ? done2 : done3;
        @(posedge clk); #1;
        commit();
        start_v[d] = 1'b0;
        if (rst_mid) begin
            skip = 1'b1;
            rst  = 1'b1;
        end else begin
            model_exec(d, op, kv, p, (d == 0) ? bl : ENTRY_EMPTY, (d == 0) ? br : ENTRY_EMPTY);
        end
        @(negedge clk);
        c_done = (d == 0) ? done2 : done3;
        c_sb   = (d == 0) ? startBot2 : startBot3;
        c_out  = (d == 0) ? out2 : out3;
        c_pb   = (d == 0) ? int'(posBot2) : int'(posBot3);
        @(posedge clk); #1;
        if (rst_mid) begin
            rst = 1'b0;
            model_reset();
            skip = 1'b0;
        end
        commit();
        set_idle(d);
    endtask

    entry_t ce;

    initial begin
        rst = 1'b1;
        tog_en = 1'b1;
        rtop2 = '0; rtop3 = '0;
        bl2 = ENTRY_EMPTY; br2 = ENTRY_EMPTY;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; op_v[d] = OP_NOP; in_v[d] = KV_EMPTY; pos_v[d] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;

        chk("reset L2 node0", rTopL2, ent(KV_EMPTY, 3, 0));
        chk("reset L2 done", done2, DONE);
        chk("reset L3 startBot", startBot3, 1'b0);

        ce = ent(KV_EMPTY, 1, 0);
        do_op(0, OP_LEQ, kvf(5, 8'h11), 0, ce, ce, 0);
        chk("leq5 wait", c_wait, WAIT);
        chk("leq5 done", c_done, DONE);
        chk("leq5 startBot", c_sb, 1'b0);
        chk("leq5 node0", rTopL2, ent(kvf(5, 8'h11), 2, 1));

        do_op(0, OP_LEQ, kvf(9, 8'h22), 0, ce, ce, 0);
        chk("leq9 done", c_done, NEXT_LEVEL);
        chk("leq9 startBot", c_sb, 1'b1);
        chk("leq9 out", c_out, kvf(5, 8'h11));
        chk("leq9 posBot", c_pb, 0);
        chk("leq9 node0", rTopL2, ent(kvf(9, 8'h22), 1, 1));

        do_op(0, OP_LEQ, kvf(7, 8'h33), 1, ce, ce, 0);
        do_op(0, OP_LEQ, kvf(1, 8'h44), 1, ent(kvf(3, 0), 0, 1), ent(kvf(2, 0), 1, 1), 0);
        chk("leq1 posBot right-only", c_pb, 3);
        do_op(0, OP_LEQ, kvf(3, 8'h45), 0, ent(kvf(6, 0), 1, 1), ent(kvf(2, 0), 0, 1), 0);
        chk("leq3 posBot left-only", c_pb, 0);
        do_op(0, OP_LEQ, kvf(12, 8'h46), 0, ent(kvf(6, 0), 1, 1), ent(kvf(2, 0), 1, 1), 0);
        chk("leq12 out", c_out, kvf(9, 8'h22));
        chk("leq12 posBot", c_pb, 1);
        chk("leq12 cap sat", rTopL2, ent(kvf(12, 8'h46), 0, 1));

        do_op(0, OP_DEQ, KV_EMPTY, 1, ent(kvf(3, 1), 0, 1), ent(kvf(8, 2), 0, 1), 0);
        chk("deq done", c_done, NEXT_LEVEL);
        chk("deq posBot", c_pb, 3);
        chk("deq node1", rTopR2, ent(kvf(8, 2), 2, 1));
        do_op(0, OP_DEQ, KV_EMPTY, 0, ent(kvf(5, 8'h55), 0, 1), ent(kvf(5, 8'h66), 0, 1), 0);
        chk("deq tie node0", rTopL2, ent(kvf(5, 8'h55), 1, 1));
        do_op(0, OP_DEQ, KV_EMPTY, 1, ENTRY_EMPTY, ENTRY_EMPTY, 0);
        chk("deq empty done", c_done, DONE);
        chk("deq empty node1", rTopR2, ent(KV_EMPTY, 3, 0));

        do_op(1, OP_NOP, kvf(1, 1), 3, ENTRY_EMPTY, ENTRY_EMPTY, 0);
        chk("nop done", c_done, DONE);
        do_op(1, OP_LEQ, kvf(4, 8'h77), 0, ENTRY_EMPTY, ENTRY_EMPTY, 0);
        do_op(1, OP_LEQ, kvf(2, 8'h78), 0, ENTRY_EMPTY, ENTRY_EMPTY, 0);
        chk("leaf full done", c_done, DONE);
        chk("leaf full startBot", c_sb, 1'b0);
        chk("leaf full err", err3, CHK);

        do_op(1, OP_LEQ, kvf(6, 8'h79), 1, ENTRY_EMPTY, ENTRY_EMPTY, 1);
        chk("rst mid done", done3, DONE);
        chk("rst mid err", err3, 1'b0);
        chk("rst mid pairL", rTopL3, ent(KV_EMPTY, 1, 0));
        chk("rst mid pairR", rTopR3, ent(KV_EMPTY, 1, 0));
        chk("rst L2 node0", rTopL2, ent(KV_EMPTY, 3, 0));

        tog_en = 1'b0;
        rtop3  = '0;
        do_op(1, OP_LEQ, kvf(8'h21, 1), 0, ENTRY_EMPTY, ENTRY_EMPTY, 0);
        do_op(1, OP_LEQ, kvf(8'h22, 2), 1, ENTRY_EMPTY, ENTRY_EMPTY, 0);
        chk("pair0 L", rTopL3, ent(kvf(8'h21, 1), 0, 1));
        chk("pair0 R", rTopR3, ent(kvf(8'h22, 2), 0, 1));
        rtop3 = 1'b1;
        #1;
        chk("pair1 L", rTopL3, ent(KV_EMPTY, 1, 0));
        tog_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pheap_level.md
# pheap_level

Generic lower-level stage of the pipelined heap (pheap) priority queue: one instance per level 2..LEVELS, chained beneath the root-level controller. Responds to an operation handed down from the level above (enqueue push-down or dequeue refill), updates one node in its own level storage, and either finishes or forwards the operation to the level below. It also serves the parent's combinational child-pair read.

## Interface
Parameters:
- LEVEL, 2, level index of this instance (root is level 1); legal range 2..LEVELS
- LEVELS, from pheapTypes, total heap depth

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous and active-high
- start  input  1  one-cycle operation request from level above
- op  input  opcode_t  LEQ or DEQ, sampled with start
- in  input  kv_t  entry pushed down (LEQ), sampled with start
- pos  input  LEVEL-1  node index within this level, sampled with start
- raddrTop  input  LEVEL-2 (min 1)  parent index for child-pair read
- rTopL, rTopR  output  entry_t  nodes {raddrTop,0} and {raddrTop,1}, combinational
- rBotL, rBotR  input  entry_t  child pair from level below (tie to ENTRY_EMPTY when LEVEL==LEVELS)
- raddrBot  output  LEVEL-1  equals latched pos
- startBot  output  1  start to level below
- opBot  output  opcode_t  op to level below
- out  output  kv_t  entry pushed to level below
- posBot  output  LEVEL  {pos, endPos}
- done  output  done_t  WAIT / NEXT_LEVEL / DONE
- err  output  1  sticky protocol error (see Configuration)

## Operation
- Storage: 2^(LEVEL-1) entries {kv, capacity, active}. Reset: kv=KV_EMPTY, active=0, capacity=2^(LEVELS-LEVEL+1)-1 (free slots in subtree).
- FSM: IDLE, EXEC. IDLE: start -> latch op/in/pos, done=WAIT, go EXEC. EXEC: execute, one write, return to IDLE.
- LEQ, node N=mem[pos]:
  - N inactive: write {in, capacity-1, active=1}; done=DONE.
  - N active: keep larger key (tie keeps N); smaller goes to out; capacity-1 saturating at 0.
  - endPos: both children capacity!=0 -> 0 if L.key<=R.key else 1; only L nonzero -> 0; else 1. done=NEXT_LEVEL, startBot=1.
  - Active N at LEVEL==LEVELS: write kept entry, done=DONE, no forward, err set.
- DEQ (N promoted by parent): capacity+1.
  - Both children inactive: write ENTRY_EMPTY kv, active=0; done=DONE.
  - Else promote child with larger key (tie -> left); active=1; endPos=side; done=NEXT_LEVEL, startBot=1, out=KV_EMPTY.
- Other op in EXEC: no write, done=DONE, err set.
- Key compare uses kv.key only, unsigned.

## Timing
- Latency 2 cycles: start at T, done=WAIT at T, result/write/startBot at T+1, memory updated at edge T+1->T+2.
- startBot, opBot, out, posBot valid only in the EXEC cycle; out=KV_EMPTY otherwise.
- rTopL/rTopR reflect contents before the write; same-cycle write visible next cycle.
- start in EXEC is ignored (parent never issues; err set).
- Reset (any state, incl. mid-EXEC): no write that cycle; next cycle IDLE, memory re-initialized, done=DONE, startBot=0, out=KV_EMPTY, posBot=0, err=0.

## Configuration
- PHEAP_LEVEL_CHECK_EN defined: err sticky register and immediate assertions for illegal op, start in EXEC, LEQ on active last-level node, DEQ on inactive node, capacity overflow.
- Undefined: no checks compiled; err tied 0; functional behaviour otherwise identical.

## Structure
- pheapTypes: entry_t, opcode_t, done_t, ENTRY_EMPTY, LEVELS, capacity-reset function of level. pq_pkg: kv_t, KV_EMPTY.
- Sub-module pheap_level_mem: 2^(LEVEL-1) entries, one sync write port, combinational pair read (raddrTop) plus single read (pos), rst re-init.

## Test plan
LEVELS=3, LEVEL=2 unless noted.
- Reset, then start LEQ in=5 pos=0 -> T done=WAIT, T+1 done=DONE, mem[0]={5,cap 2,active}, startBot=0.
- mem[0]=5, LEQ in=9 pos=0, children empty cap 1 -> mem[0]=9, out=5, posBot=2'b00, startBot=1, done=NEXT_LEVEL.
- mem[1]=7, children keys 3/8 active, DEQ pos=1 -> mem[1]=8 active, posBot=2'b11, done=NEXT_LEVEL; both children inactive -> mem[1] inactive, done=DONE, capacity+1.
- LEVEL=3, active node key 4, LEQ in=2 -> kept 4, done=DONE, startBot=0, err=1 (check enabled).
- rst asserted in EXEC of LEQ in=6 -> no write, next cycle IDLE, all nodes capacity 1, inactive.
- raddrTop=0 after writes at nodes 0,1 -> rTopL/rTopR show written entries the cycle after the write.
